// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose
//   Runs up to eight pipelined-loop stages one after another, using
//   ap_start/ap_ready/ap_done style handshakes. A top-level start latches a
//   per-stage bypass mask. Each stage that is not bypassed is started in
//   ascending index order, and the run ends in a DONE state. That state holds
//   ap_done until ap_continue is seen.
//
// Parameters
//   N_STAGES : number of sequenced stages (1..8)
//   CNT_W    : width of each per-stage latency counter
//
// Ports
//   ap_clk       in   clock, rising edge
//   ap_rst       in   synchronous active-high reset
//   ap_start     in   top-level start request (only honoured in IDLE)
//   ap_continue  in   acknowledge of ap_done
//   stg_bypass   in   [N_STAGES]  skip mask, sampled when a run is accepted
//   stg_start    out  [N_STAGES]  per-stage ap_start (at most one bit high)
//   stg_ready    in   [N_STAGES]  per-stage ap_ready
//   stg_done     in   [N_STAGES]  per-stage ap_done
//   ap_done      out  run complete, held until ap_continue
//   ap_ready     out  one-cycle pulse when a run is accepted
//   ap_idle      out  sequencer is in IDLE
//   cur_stage    out  [3]  index of the active stage, 0 when not running
//   stg_cycles   out  [N_STAGES*CNT_W]  per-stage latency counters
//
// Configuration
//   STAGE_SEQ_PERF_CNT_EN : when defined, stg_cycles[k] counts the active
//   cycles of stage k. A stage is active from its first stg_start cycle
//   through its stg_done cycle. Each counter saturates, is cleared when a
//   run is accepted and holds its value until the next acceptance. When the
//   macro is undefined, stg_cycles is tied to zero and no counter state
//   exists.
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       ap_start,
  input  logic                       ap_continue,
  input  logic [N_STAGES-1:0]        stg_bypass,
  output logic [N_STAGES-1:0]        stg_start,
  input  logic [N_STAGES-1:0]        stg_ready,
  input  logic [N_STAGES-1:0]        stg_done,
  output logic                       ap_done,
  output logic                       ap_ready,
  output logic                       ap_idle,
  output logic [2:0]                 cur_stage,
  output logic [N_STAGES*CNT_W-1:0]  stg_cycles
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cur_q, cur_d;
  logic [N_STAGES-1:0] bypass_q, bypass_d;
  logic [N_STAGES-1:0] start_q, start_d;
  // Set once the active stage has accepted; stg_start stays low while
  // waiting for its stg_done.
  logic                acc_q, acc_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                idle_q, idle_d;

  logic [N_STAGES-1:0] cur_oh;
  logic                first_found, next_found;
  logic [2:0]          first_idx, next_idx;
  logic                act_started, act_ready, act_done;

  // One-hot select of the running stage, so only its handshakes are observed.
  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      cur_oh[i] = (3'(i) == cur_q);
    end
  end

  assign act_started = |(start_q & cur_oh);
  assign act_ready   = |(stg_ready & cur_oh);
  assign act_done    = |(stg_done & cur_oh);

  // First stage of a new run, taken from the live bypass input because the
  // mask is latched on that same edge.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int j = int'(N_STAGES) - 1; j >= 0; j--) begin
      if (!stg_bypass[j]) begin
        first_found = 1'b1;
        first_idx   = 3'(j);
      end
    end
  end

  // Lowest stage above the current one that is not bypassed.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int j = int'(N_STAGES) - 1; j >= 0; j--) begin
      if (!bypass_q[j] && (3'(j) > cur_q)) begin
        next_found = 1'b1;
        next_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    bypass_d = bypass_q;
    start_d  = start_q;
    acc_d    = acc_q;
    ready_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (ap_start) begin
          bypass_d = stg_bypass;
          ready_d  = 1'b1;
          start_d  = '0;
          acc_d    = 1'b0;
          if (first_found) begin
            state_d = StRun;
            cur_d   = first_idx;
          end else begin
            state_d = StDone;
            cur_d   = '0;
          end
        end
      end

      StRun: begin
        if (!act_started && !acc_q) begin
          // Entry cycle: the stage has not been started yet. Its handshakes
          // cannot refer to this run, so they are ignored.
          start_d = cur_oh;
        end else if (act_done) begin
          // A done that arrives together with ready counts as both.
          start_d = '0;
          acc_d   = 1'b0;
          if (next_found) begin
            cur_d = next_idx;
          end else begin
            state_d = StDone;
            cur_d   = '0;
          end
        end else if (act_ready) begin
          start_d = '0;
          acc_d   = 1'b1;
        end
      end

      StDone: begin
        if (ap_continue) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cur_d   = '0;
        start_d = '0;
        acc_d   = 1'b0;
      end
    endcase

    done_d = (state_d == StDone);
    idle_d = (state_d == StIdle);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      bypass_q <= '0;
      start_q  <= '0;
      acc_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      bypass_q <= bypass_d;
      start_q  <= start_d;
      acc_q    <= acc_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
    end
  end

  assign stg_start = start_q;
  assign cur_stage = cur_q;
  assign ap_ready  = ready_q;
  assign ap_done   = done_q;
  assign ap_idle   = idle_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0]    cnt_q [N_STAGES];
  logic [CNT_W-1:0]    cnt_d [N_STAGES];
  logic                run_accept;
  logic [N_STAGES-1:0] stage_active;

  always_comb begin
    run_accept   = (state_q == StIdle) && ap_start;
    stage_active = '0;
    if ((state_q == StRun) && (act_started || acc_q)) begin
      stage_active = cur_oh;
    end
    stg_cycles = '0;
    for (int k = 0; k < int'(N_STAGES); k++) begin
      cnt_d[k] = cnt_q[k];
      if (run_accept) begin
        cnt_d[k] = '0;
      end else if (stage_active[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      stg_cycles[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 0; k < int'(N_STAGES); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stg_cycles = '0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//
// Self-checking bench for stage_sequencer. For each run, the expected timeline
// is computed from the stage schedule: when each stage starts, when it
// accepts and completes, and when ap_done appears. The DUT is then compared
// against that timeline every cycle. Stage responses come from the schedule,
// not from the DUT. A second instance (N_STAGES=1, CNT_W=4) covers counter
// saturation.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
  localparam int N    = 3;
  localparam int W    = 32;
  localparam int MAXC = 128;

  logic           ap_clk = 1'b0;
  logic           ap_rst, ap_start, ap_continue;
  logic [N-1:0]   stg_bypass, stg_start, stg_ready, stg_done;
  logic           ap_done, ap_ready, ap_idle;
  logic [2:0]     cur_stage;
  logic [N*W-1:0] stg_cycles;

  logic           s_start, s_continue;
  logic [0:0]     s_bypass, s_stg_start, s_stg_ready, s_stg_done;
  logic           s_done, s_ready, s_idle;
  logic [2:0]     s_cur;
  logic [3:0]     s_cycles;

  always #5 ap_clk = ~ap_clk;

  stage_sequencer #(.N_STAGES(N), .CNT_W(W)) u_dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_continue (ap_continue),
    .stg_bypass  (stg_bypass),
    .stg_start   (stg_start),
    .stg_ready   (stg_ready),
    .stg_done    (stg_done),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .cur_stage   (cur_stage),
    .stg_cycles  (stg_cycles)
  );

  stage_sequencer #(.N_STAGES(1), .CNT_W(4)) u_sat (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (s_start),
    .ap_continue (s_continue),
    .stg_bypass  (s_bypass),
    .stg_start   (s_stg_start),
    .stg_ready   (s_stg_ready),
    .stg_done    (s_stg_done),
    .ap_done     (s_done),
    .ap_ready    (s_ready),
    .ap_idle     (s_idle),
    .cur_stage   (s_cur),
    .stg_cycles  (s_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Run configuration consumed by run_trace.
  logic [N-1:0] cfg_byp;
  int           cfg_r [N];
  int           cfg_d [N];
  int           cfg_wait;
  int           cfg_gap;
  int           meas_done;

  // Outputs packed as {stg_start, cur_stage, ap_ready, ap_done, ap_idle}.
  task automatic run_trace();
    logic [N-1:0] e_start [MAXC];
    logic [2:0]   e_cur   [MAXC];
    logic         e_run   [MAXC];
    logic         e_rdy   [MAXC];
    logic         e_done  [MAXC];
    logic         e_idle  [MAXC];
    logic [N-1:0] i_rdy   [MAXC];
    logic [N-1:0] i_done  [MAXC];
    logic [W-1:0] e_cnt   [N];
    logic [N-1:0] mask, nz_r, nz_d;
    int pos, s, dstart, last;

    for (int c = 0; c < MAXC; c++) begin
      e_start[c] = '0; e_cur[c] = '0; e_run[c] = 1'b0; e_rdy[c] = 1'b0;
      e_done[c] = 1'b0; e_idle[c] = 1'b0; i_rdy[c] = '0; i_done[c] = '0;
    end
    // Cycle 0 carries ap_start in IDLE; the run is accepted at its end.
    e_idle[0] = 1'b1;
    e_rdy[1]  = 1'b1;
    pos = 1;
    for (int k = 0; k < N; k++) begin
      e_cnt[k] = '0;
      if (!cfg_byp[k]) begin
        s = pos + 1;
        for (int c = pos; c <= s + cfg_d[k]; c++) begin
          e_cur[c] = 3'(k);
          e_run[c] = 1'b1;
        end
        for (int c = s; c <= s + cfg_r[k]; c++) e_start[c][k] = 1'b1;
        i_rdy[s + cfg_r[k]][k]  = 1'b1;
        i_done[s + cfg_d[k]][k] = 1'b1;
`ifdef STAGE_SEQ_PERF_CNT_EN
        e_cnt[k] = W'(cfg_d[k] + 1);
`endif
        pos = s + cfg_d[k] + 1;
      end
    end
    dstart = pos;
    last   = dstart + cfg_wait;
    for (int c = dstart; c <= last; c++) e_done[c] = 1'b1;

    for (int g = 0; g < cfg_gap; g++) begin
      check("idle gap {start,cur,rdy,done,idle}",
            {stg_start, cur_stage, ap_ready, ap_done, ap_idle}, {{N{1'b0}}, 3'd0, 3'b001});
      ap_start    = 1'b0;
      ap_continue = 1'($urandom);
      stg_bypass  = N'($urandom);
      stg_ready   = N'($urandom) & N'($urandom);
      stg_done    = N'($urandom) & N'($urandom);
      @(negedge ap_clk);
    end

    meas_done = -1;
    for (int c = 0; c <= last; c++) begin
      check($sformatf("trace {start,cur,rdy,done,idle} c=%0d", c),
            {stg_start, cur_stage, ap_ready, ap_done, ap_idle},
            {e_start[c], e_cur[c], e_rdy[c], e_done[c], e_idle[c]});
      if (ap_done === 1'b1 && meas_done < 0) meas_done = c;
      if (c == 1) check("counters cleared", 64'(stg_cycles), 64'd0);
      if (c == dstart) begin
        for (int k = 0; k < N; k++) begin
          check($sformatf("stg_cycles[%0d]", k), 64'(stg_cycles[k*W +: W]), 64'(e_cnt[k]));
        end
      end
      mask = e_run[c] ? (N'(1) << e_cur[c]) : '0;
      nz_r = N'($urandom) & N'($urandom) & ~mask;
      nz_d = N'($urandom) & N'($urandom) & ~mask;
      ap_start    = (c == 0) ? 1'b1 : 1'($urandom);
      stg_bypass  = (c == 0) ? cfg_byp : N'($urandom);
      ap_continue = (c >= dstart) ? (c == last) : 1'($urandom);
      stg_ready   = i_rdy[c] | nz_r;
      stg_done    = i_done[c] | nz_d;
      @(negedge ap_clk);
    end
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    stg_ready   = '0;
    stg_done    = '0;
  endtask

  typedef struct packed {
    logic [N-1:0]      byp;
    logic [N-1:0][7:0] r;
    logic [N-1:0][7:0] d;
    logic [7:0]        wt;
    logic [7:0]        exp_done;
    logic [N-1:0][7:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // Stage fields are listed {stage2, stage1, stage0}.
    vecs[0] = '{byp: 3'b000, r: {8'd5, 8'd5, 8'd5}, d: {8'd5, 8'd5, 8'd5},
                wt: 8'd0, exp_done: 8'd22, exp_cnt: {8'd6, 8'd6, 8'd6}};
    vecs[1] = '{byp: 3'b010, r: {8'd3, 8'd0, 8'd2}, d: {8'd3, 8'd0, 8'd2},
                wt: 8'd0, exp_done: 8'd10, exp_cnt: {8'd4, 8'd0, 8'd3}};
    vecs[2] = '{byp: 3'b111, r: {8'd0, 8'd0, 8'd0}, d: {8'd0, 8'd0, 8'd0},
                wt: 8'd0, exp_done: 8'd1, exp_cnt: {8'd0, 8'd0, 8'd0}};
    vecs[3] = '{byp: 3'b000, r: {8'd2, 8'd1, 8'd0}, d: {8'd4, 8'd1, 8'd3},
                wt: 8'd4, exp_done: 8'd15, exp_cnt: {8'd5, 8'd2, 8'd4}};
    vecs[4] = '{byp: 3'b100, r: {8'd0, 8'd0, 8'd0}, d: {8'd0, 8'd0, 8'd0},
                wt: 8'd1, exp_done: 8'd5, exp_cnt: {8'd0, 8'd1, 8'd1}};
    vecs[5] = '{byp: 3'b011, r: {8'd1, 8'd0, 8'd0}, d: {8'd2, 8'd0, 8'd0},
                wt: 8'd2, exp_done: 8'd5, exp_cnt: {8'd3, 8'd0, 8'd0}};

    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
    stg_bypass = '0; stg_ready = '0; stg_done = '0;
    s_start = 1'b0; s_continue = 1'b1; s_bypass = '0; s_stg_ready = '0; s_stg_done = '0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    check("reset {start,cur,rdy,done,idle}",
          {stg_start, cur_stage, ap_ready, ap_done, ap_idle}, {{N{1'b0}}, 3'd0, 3'b001});
    check("reset stg_cycles", 64'(stg_cycles), 64'd0);
    check("reset sat idle", {s_stg_start, s_done, s_idle}, 3'b001);
    ap_rst = 1'b0;
    @(negedge ap_clk);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      cfg_byp = vecs[v].byp;
      for (int k = 0; k < N; k++) begin
        cfg_r[k] = int'(vecs[v].r[k]);
        cfg_d[k] = int'(vecs[v].d[k]);
      end
      cfg_wait = int'(vecs[v].wt);
      cfg_gap  = 1;
      run_trace();
      check($sformatf("vec%0d done cycle", v), 64'(meas_done), 64'(vecs[v].exp_done));
      for (int k = 0; k < N; k++) begin
`ifdef STAGE_SEQ_PERF_CNT_EN
        check($sformatf("vec%0d cnt[%0d]", v, k), 64'(stg_cycles[k*W +: W]),
              64'(vecs[v].exp_cnt[k]));
`else
        check($sformatf("vec%0d cnt[%0d]", v, k), 64'(stg_cycles[k*W +: W]), 64'd0);
`endif
      end
    end

    // Randomized runs against the schedule model.
    for (int n = 0; n < 40; n++) begin
      cfg_byp = N'($urandom);
      for (int k = 0; k < N; k++) begin
        cfg_r[k] = int'($urandom_range(0, 3));
        cfg_d[k] = cfg_r[k] + int'($urandom_range(0, 4));
      end
      cfg_wait = int'($urandom_range(0, 4));
      cfg_gap  = int'($urandom_range(0, 2));
      run_trace();
    end

    // Reset while stage 1 is running.
    stg_bypass = '0; ap_start = 1'b1; ap_continue = 1'b0;
    @(negedge ap_clk);
    check("rst_seq ready", {ap_ready, ap_idle}, 2'b10);
    ap_start = 1'b0;
    @(negedge ap_clk);
    check("rst_seq start0", {cur_stage, stg_start}, {3'd0, 3'b001});
    stg_ready = 3'b001; stg_done = 3'b001;
    @(negedge ap_clk);
    check("rst_seq entry1", {cur_stage, stg_start}, {3'd1, 3'b000});
    stg_ready = '0; stg_done = '0;
    @(negedge ap_clk);
    check("rst_seq start1", {cur_stage, stg_start}, {3'd1, 3'b010});
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("rst_seq after reset", {stg_start, cur_stage, ap_ready, ap_done, ap_idle},
          {3'b000, 3'd0, 3'b001});
    check("rst_seq counters", 64'(stg_cycles), 64'd0);
    ap_rst = 1'b0; stg_ready = 3'b010; stg_done = 3'b010;
    @(negedge ap_clk);
    check("rst_seq late done ignored", {stg_start, cur_stage, ap_ready, ap_done, ap_idle},
          {3'b000, 3'd0, 3'b001});
    stg_ready = '0; stg_done = '0; ap_start = 1'b1;
    @(negedge ap_clk);
    check("rst_seq rerun accept", {stg_start, cur_stage, ap_ready, ap_idle},
          {3'b000, 3'd0, 2'b10});
    ap_start = 1'b0;
    @(negedge ap_clk);
    check("rst_seq rerun stage0", {stg_start, cur_stage}, {3'b001, 3'd0});
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check("rst_seq final idle", {stg_start, ap_idle}, {3'b000, 1'b1});
    @(negedge ap_clk);

    // Saturation: one 20-cycle stage with a 4-bit counter.
    s_start = 1'b1;
    @(negedge ap_clk);
    check("sat ready", s_ready, 1'b1);
    s_start = 1'b0;
    @(negedge ap_clk);
    check("sat start", {s_stg_start, s_cur}, {1'b1, 3'd0});
    for (int c = 2; c < 21; c++) @(negedge ap_clk);
    s_stg_ready = 1'b1; s_stg_done = 1'b1;
    @(negedge ap_clk);
    s_stg_ready = 1'b0; s_stg_done = 1'b0;
    check("sat done", {s_done, s_stg_start}, 2'b10);
    @(negedge ap_clk);
    check("sat idle", s_idle, 1'b1);
`ifdef STAGE_SEQ_PERF_CNT_EN
    check("sat cycles", 64'(s_cycles), 64'd15);
`else
    check("sat cycles", 64'(s_cycles), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
